// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel filter/apply pair: default channel widths and
// the per-frame coefficient record that pixel_filt produces and pixel_apply consumes.
package pixel_pkg;

    localparam int CH_W_DEFAULT  = 8;
    localparam int MOD_W_DEFAULT = 6;

    typedef struct packed {
        logic [MOD_W_DEFAULT-1:0] r;
        logic [MOD_W_DEFAULT-1:0] g;
        logic [MOD_W_DEFAULT-1:0] b;
        logic                     div;
    } coef_t;

    // Unity multiply: pixels pass through unchanged.
    localparam coef_t COEF_PASSTHROUGH = '{
        r:   MOD_W_DEFAULT'(1),
        g:   MOD_W_DEFAULT'(1),
        b:   MOD_W_DEFAULT'(1),
        div: 1'b0
    };

endpackage

// File: rtl/chan_scale.sv
// One colour channel: saturating multiply, or power-of-two divide by shifting
// right by the index of the modifier's leading one.
module chan_scale #(
    parameter int CH_W  = 8,
    parameter int MOD_W = 6
) (
    input  logic [CH_W-1:0]  pix_i,
    input  logic [MOD_W-1:0] mod_i,
    input  logic             div_i,
    output logic [CH_W-1:0]  out_o
);

    localparam int PROD_W = CH_W + MOD_W;
    localparam int SH_W   = (MOD_W > 1) ? $clog2(MOD_W) : 1;
    localparam logic [PROD_W-1:0] SAT_MAX = PROD_W'({CH_W{1'b1}});

    logic [PROD_W-1:0] prod;
    logic [SH_W-1:0]   shift;

    assign prod = PROD_W'(pix_i) * PROD_W'(mod_i);

    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    always_comb begin
        shift = '0;
        for (int i = 0; i < MOD_W; i++) begin
            if (mod_i[i]) shift = SH_W'(i);
        end

        out_o = '0;
        if (!div_i) begin
            out_o = (prod > SAT_MAX) ? {CH_W{1'b1}} : prod[CH_W-1:0];
        end else if (mod_i != '0) begin
            out_o = pix_i >> shift;
        end
    end

endmodule

// File: rtl/pixel_apply.sv
// Two-stage pixel scaler: stage 1 captures the pixel with its frame coefficients,
// stage 2 registers the scaled, saturated result onto the output stream.
module pixel_apply
    import pixel_pkg::*;
#(
    parameter int CH_W  = CH_W_DEFAULT,
    parameter int MOD_W = MOD_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MOD_W-1:0]    r_mod,
    input  logic [MOD_W-1:0]    g_mod,
    input  logic [MOD_W-1:0]    b_mod,
    input  logic                div_flag,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [3*CH_W-1:0]   s_data,
    input  logic                s_sof,
    input  logic                s_eol,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [3*CH_W-1:0]   m_data,
    output logic                m_sof,
    output logic                m_eol
);

    localparam int PIX_W = 3 * CH_W;

    // Shadow and stage-1 coefficients use the pixel_pkg widths; MOD_W must match.
    coef_t shadow_q, shadow_d;
    coef_t s1_coef_q, s1_coef_d;
    coef_t new_coef;

    logic [PIX_W-1:0] s1_pix_q, s1_pix_d;
    logic             s1_sof_q, s1_sof_d;
    logic             s1_eol_q, s1_eol_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [PIX_W-1:0] m_data_q, m_data_d;
    logic             m_sof_q, m_sof_d;
    logic             m_eol_q, m_eol_d;

    logic             adv2;
    logic             accept;
    logic [CH_W-1:0]  r_out, g_out, b_out;

    assign new_coef = '{r: r_mod, g: g_mod, b: b_mod, div: div_flag};

    // Stage 2 can take a beat when empty or when its beat leaves this cycle.
    assign adv2    = !v2_q || m_ready;
    assign s_ready = !v1_q || adv2;
    assign accept  = s_valid && s_ready;

    chan_scale #(.CH_W(CH_W), .MOD_W(MOD_W)) u_scale_r (
        .pix_i (s1_pix_q[3*CH_W-1:2*CH_W]),
        .mod_i (s1_coef_q.r),
        .div_i (s1_coef_q.div),
        .out_o (r_out)
    );

    chan_scale #(.CH_W(CH_W), .MOD_W(MOD_W)) u_scale_g (
        .pix_i (s1_pix_q[2*CH_W-1:CH_W]),
        .mod_i (s1_coef_q.g),
        .div_i (s1_coef_q.div),
        .out_o (g_out)
    );

    chan_scale #(.CH_W(CH_W), .MOD_W(MOD_W)) u_scale_b (
        .pix_i (s1_pix_q[CH_W-1:0]),
        .mod_i (s1_coef_q.b),
        .div_i (s1_coef_q.div),
        .out_o (b_out)
    );

    always_comb begin
        shadow_d  = shadow_q;
        s1_coef_d = s1_coef_q;
        s1_pix_d  = s1_pix_q;
        s1_sof_d  = s1_sof_q;
        s1_eol_d  = s1_eol_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        m_data_d  = m_data_q;
        m_sof_d   = m_sof_q;
        m_eol_d   = m_eol_q;

        if (accept && s_sof) shadow_d = new_coef;

        if (s_ready) begin
            v1_d = s_valid;
            if (s_valid) begin
                // The sof beat itself already uses the freshly captured coefficients.
                s1_coef_d = s_sof ? new_coef : shadow_q;
                s1_pix_d  = s_data;
                s1_sof_d  = s_sof;
                s1_eol_d  = s_eol;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                m_data_d = {r_out, g_out, b_out};
                m_sof_d  = s1_sof_q;
                m_eol_d  = s1_eol_q;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= COEF_PASSTHROUGH;
            s1_coef_q <= COEF_PASSTHROUGH;
            s1_pix_q  <= '0;
            s1_sof_q  <= 1'b0;
            s1_eol_q  <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            s1_coef_q <= s1_coef_d;
            s1_pix_q  <= s1_pix_d;
            s1_sof_q  <= s1_sof_d;
            s1_eol_q  <= s1_eol_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            m_data_q  <= m_data_d;
            m_sof_q   <= m_sof_d;
            m_eol_q   <= m_eol_d;
        end
    end

    assign m_valid = v2_q;
    assign m_data  = m_data_q;
    assign m_sof   = m_sof_q;
    assign m_eol   = m_eol_q;

endmodule
